// File: rtl/ysyx_210544_wb_stage_pkg.sv
// Shared widths and writeback FSM encodings for the ysyx_210544 writeback stage.
// Optional feature macro used by importers: YSYX_210544_WB_PERF_EN.
package ysyx_210544_wb_stage_pkg;
  localparam int BUS_64 = 64;
  localparam int BUS_32 = 32;

  localparam logic [0:0] WB_EMPTY = 1'b0;
  localparam logic [0:0] WB_HOLD  = 1'b1;
endpackage

// File: rtl/ysyx_210544_wb_perf.sv
// Retired-instruction and cycle counters for the writeback stage.
// Instantiated only when YSYX_210544_WB_PERF_EN is defined.
module ysyx_210544_wb_perf
  import ysyx_210544_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmt_fire,
  output logic [BUS_64-1:0] o_instret,
  output logic [BUS_64-1:0] o_cycle
);

  logic [BUS_64-1:0] r_instret;
  logic [BUS_64-1:0] r_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= '0;
      r_cycle   <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (i_cmt_fire) r_instret <= r_instret + 64'd1;
    end
  end

  assign o_instret = r_instret;
  assign o_cycle   = r_cycle;

endmodule

// File: rtl/ysyx_210544_wb_stage.sv
// Writeback stage: one-entry skid holding the retiring instruction, pulsing the
// regfile write once per entry. Perf counters gated by YSYX_210544_WB_PERF_EN.
module ysyx_210544_wb_stage
  import ysyx_210544_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_memoryed_req,
  output logic              o_wb_memoryed_ack,
  input  logic [4:0]        i_wb_rd,
  input  logic              i_wb_rd_wen,
  input  logic [BUS_64-1:0] i_wb_rd_wdata,
  input  logic [BUS_64-1:0] i_wb_pc,
  input  logic [BUS_32-1:0] i_wb_inst,
  input  logic              i_wb_nocmt,
  input  logic              i_wb_skipcmt,
  input  logic [BUS_32-1:0] i_wb_intrNo,
  output logic [4:0]        o_wb_rd,
  output logic              o_wb_rd_wen,
  output logic [BUS_64-1:0] o_wb_rd_wdata,
  output logic              o_wb_writebacked_req,
  input  logic              i_wb_writebacked_ack,
  output logic [4:0]        o_wb_cmt_rd,
  output logic              o_wb_cmt_rd_wen,
  output logic [BUS_64-1:0] o_wb_cmt_rd_wdata,
  output logic [BUS_64-1:0] o_wb_cmt_pc,
  output logic [BUS_32-1:0] o_wb_cmt_inst,
  output logic              o_wb_cmt_nocmt,
  output logic              o_wb_cmt_skipcmt,
  output logic [BUS_32-1:0] o_wb_cmt_intrNo,
  output logic [BUS_64-1:0] o_wb_perf_instret,
  output logic [BUS_64-1:0] o_wb_perf_cycle
);

  logic [0:0]        r_state;
  logic              r_first;
  logic [4:0]        r_rd;
  logic              r_rd_wen;
  logic [BUS_64-1:0] r_rd_wdata;
  logic [BUS_64-1:0] r_pc;
  logic [BUS_32-1:0] r_inst;
  logic              r_nocmt;
  logic              r_skipcmt;
  logic [BUS_32-1:0] r_intrNo;

  logic w_hold;
  logic w_drain;
  logic w_mack;
  logic w_capture;

  assign w_hold    = (r_state == WB_HOLD);
  assign w_drain   = w_hold & i_wb_writebacked_ack;
  // Accept when empty or when the held entry leaves this same cycle.
  assign w_mack    = ~rst & (~w_hold | w_drain);
  assign w_capture = i_wb_memoryed_req & w_mack;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= WB_EMPTY;
      r_first    <= 1'b0;
      r_rd       <= '0;
      r_rd_wen   <= 1'b0;
      r_rd_wdata <= '0;
      r_pc       <= '0;
      r_inst     <= '0;
      r_nocmt    <= 1'b0;
      r_skipcmt  <= 1'b0;
      r_intrNo   <= '0;
    end else if (w_capture) begin
      r_state    <= WB_HOLD;
      r_first    <= 1'b1;
      r_rd       <= i_wb_rd;
      r_rd_wen   <= i_wb_rd_wen;
      r_rd_wdata <= i_wb_rd_wdata;
      r_pc       <= i_wb_pc;
      r_inst     <= i_wb_inst;
      r_nocmt    <= i_wb_nocmt;
      r_skipcmt  <= i_wb_skipcmt;
      r_intrNo   <= i_wb_intrNo;
    end else begin
      r_first <= 1'b0;
      if (w_drain) r_state <= WB_EMPTY;
    end
  end

  assign o_wb_memoryed_ack    = w_mack;
  assign o_wb_writebacked_req = ~rst & w_hold;

  // Regfile write fires only on the entry's first cycle, and never for x0.
  assign o_wb_rd_wen   = ~rst & r_first & r_rd_wen & (r_rd != 5'd0);
  assign o_wb_rd       = rst ? 5'd0 : r_rd;
  assign o_wb_rd_wdata = rst ? '0 : r_rd_wdata;

  assign o_wb_cmt_rd       = rst ? 5'd0 : r_rd;
  assign o_wb_cmt_rd_wen   = ~rst & r_rd_wen;
  assign o_wb_cmt_rd_wdata = rst ? '0 : r_rd_wdata;
  assign o_wb_cmt_pc       = rst ? '0 : r_pc;
  assign o_wb_cmt_inst     = rst ? '0 : r_inst;
  assign o_wb_cmt_nocmt    = ~rst & r_nocmt;
  assign o_wb_cmt_skipcmt  = ~rst & r_skipcmt;
  assign o_wb_cmt_intrNo   = rst ? '0 : r_intrNo;

`ifdef YSYX_210544_WB_PERF_EN
  logic              w_cmt_fire;
  logic [BUS_64-1:0] w_instret;
  logic [BUS_64-1:0] w_cycle;

  assign w_cmt_fire = ~rst & w_drain & ~r_nocmt;

  ysyx_210544_wb_perf u_perf (
    .clk        (clk),
    .rst        (rst),
    .i_cmt_fire (w_cmt_fire),
    .o_instret  (w_instret),
    .o_cycle    (w_cycle)
  );

  assign o_wb_perf_instret = rst ? '0 : w_instret;
  assign o_wb_perf_cycle   = rst ? '0 : w_cycle;
`else
  assign o_wb_perf_instret = '0;
  assign o_wb_perf_cycle   = '0;
`endif

endmodule

// File: tb/tb_ysyx_210544_wb_stage.sv
// Self-checking bench for ysyx_210544_wb_stage: directed scenarios plus random
// traffic against a queue-based model of the one-entry writeback buffer.
module tb_ysyx_210544_wb_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wdata;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        nocmt;
    logic        skipcmt;
    logic [31:0] intrNo;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic        o_mack;
  logic [4:0]  i_rd;
  logic        i_rd_wen;
  logic [63:0] i_rd_wdata;
  logic [63:0] i_pc;
  logic [31:0] i_inst;
  logic        i_nocmt;
  logic        i_skipcmt;
  logic [31:0] i_intrNo;
  logic [4:0]  o_rd;
  logic        o_rd_wen;
  logic [63:0] o_rd_wdata;
  logic        o_wreq;
  logic        i_wack;
  logic [4:0]  o_c_rd;
  logic        o_c_rd_wen;
  logic [63:0] o_c_rd_wdata;
  logic [63:0] o_c_pc;
  logic [31:0] o_c_inst;
  logic        o_c_nocmt;
  logic        o_c_skipcmt;
  logic [31:0] o_c_intrNo;
  logic [63:0] o_instret;
  logic [63:0] o_cycle;

  always #5 clk = ~clk;

  ysyx_210544_wb_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_wb_memoryed_req    (i_req),
    .o_wb_memoryed_ack    (o_mack),
    .i_wb_rd              (i_rd),
    .i_wb_rd_wen          (i_rd_wen),
    .i_wb_rd_wdata        (i_rd_wdata),
    .i_wb_pc              (i_pc),
    .i_wb_inst            (i_inst),
    .i_wb_nocmt           (i_nocmt),
    .i_wb_skipcmt         (i_skipcmt),
    .i_wb_intrNo          (i_intrNo),
    .o_wb_rd              (o_rd),
    .o_wb_rd_wen          (o_rd_wen),
    .o_wb_rd_wdata        (o_rd_wdata),
    .o_wb_writebacked_req (o_wreq),
    .i_wb_writebacked_ack (i_wack),
    .o_wb_cmt_rd          (o_c_rd),
    .o_wb_cmt_rd_wen      (o_c_rd_wen),
    .o_wb_cmt_rd_wdata    (o_c_rd_wdata),
    .o_wb_cmt_pc          (o_c_pc),
    .o_wb_cmt_inst        (o_c_inst),
    .o_wb_cmt_nocmt       (o_c_nocmt),
    .o_wb_cmt_skipcmt     (o_c_skipcmt),
    .o_wb_cmt_intrNo      (o_c_intrNo),
    .o_wb_perf_instret    (o_instret),
    .o_wb_perf_cycle      (o_cycle)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: pending entries (at most one), cycles the head has been offered,
  // last captured entry, and the two counters.
  ent_t        q[$];
  int          age;
  ent_t        last;
  logic [63:0] m_cyc;
  logic [63:0] m_ins;
  int          n_handshakes;
  int          n_pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    e.rd      = 5'($urandom_range(0, 31));
    e.wen     = 1'($urandom_range(0, 3) != 0);
    e.wdata   = {$urandom, $urandom};
    e.pc      = {32'h0, $urandom} & 64'hFFFF_FFFC;
    e.inst    = $urandom;
    e.nocmt   = 1'($urandom_range(0, 3) == 0);
    e.skipcmt = 1'($urandom_range(0, 1));
    e.intrNo  = $urandom_range(0, 15);
    return e;
  endfunction

  function automatic ent_t mk(input logic [4:0] rd, input logic wen,
                              input logic [63:0] wd, input logic nc);
    ent_t e;
    e.rd      = rd;
    e.wen     = wen;
    e.wdata   = wd;
    e.pc      = 64'h8000_0000 + {59'd0, rd} * 4;
    e.inst    = 32'h0000_0013 | {27'd0, rd} << 7;
    e.nocmt   = nc;
    e.skipcmt = 1'b0;
    e.intrNo  = 32'd0;
    return e;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic step(input logic rs, input logic rq, input ent_t e, input logic ak);
    logic        valid;
    logic        e_mack;
    logic        e_pulse;
    logic [63:0] e_ins;
    logic [63:0] e_cyc;
    rst = rs; i_req = rq; i_wack = ak;
    i_rd = e.rd; i_rd_wen = e.wen; i_rd_wdata = e.wdata; i_pc = e.pc;
    i_inst = e.inst; i_nocmt = e.nocmt; i_skipcmt = e.skipcmt; i_intrNo = e.intrNo;
    #4;
    valid   = !rs && (q.size() != 0);
    e_mack  = !rs && (q.size() == 0 || ak);
    e_pulse = valid && age == 0 && q[0].wen && q[0].rd != 5'd0;
`ifdef YSYX_210544_WB_PERF_EN
    e_ins = rs ? 64'd0 : m_ins;
    e_cyc = rs ? 64'd0 : m_cyc;
`else
    e_ins = 64'd0;
    e_cyc = 64'd0;
`endif
    chk("wb_req", 64'(o_wreq), 64'(valid));
    chk("mem_ack", 64'(o_mack), 64'(e_mack));
    chk("rd_wen", 64'(o_rd_wen), 64'(e_pulse));
    chk("rd", 64'(o_rd), rs ? 64'd0 : 64'(last.rd));
    chk("rd_wdata", o_rd_wdata, rs ? 64'd0 : last.wdata);
    chk("instret", o_instret, e_ins);
    chk("cycle", o_cycle, e_cyc);
    if (rs) begin
      chk("rst_cmt_pc", o_c_pc, 64'd0);
      chk("rst_cmt_misc", {o_c_inst, o_c_intrNo},
          64'({o_c_rd, o_c_rd_wen, o_c_nocmt, o_c_skipcmt} != 0));
      chk("rst_cmt_wdata", o_c_rd_wdata, 64'd0);
    end else if (valid) begin
      chk("cmt_rd", 64'(o_c_rd), 64'(q[0].rd));
      chk("cmt_rd_wen", 64'(o_c_rd_wen), 64'(q[0].wen));
      chk("cmt_wdata", o_c_rd_wdata, q[0].wdata);
      chk("cmt_pc", o_c_pc, q[0].pc);
      chk("cmt_inst_intr", {o_c_inst, o_c_intrNo}, {q[0].inst, q[0].intrNo});
      chk("cmt_flags", 64'({o_c_nocmt, o_c_skipcmt}), 64'({q[0].nocmt, q[0].skipcmt}));
    end
    if (e_pulse) n_pulses++;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      last  = '0;
      age   = 0;
      m_cyc = 0;
      m_ins = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (valid && ak) begin
        n_handshakes++;
        if (!q[0].nocmt) m_ins = m_ins + 1;
        void'(q.pop_front());
      end
      if (rq && e_mack) begin
        q.push_back(e);
        last = e;
        age  = 0;
      end else begin
        age++;
      end
    end
  endtask

  initial begin
    ent_t        z;
    ent_t        e;
    logic [63:0] ins0;
    int          h0;
    int          p0;
    z = '0;
    q.delete(); last = '0; age = 0; m_cyc = 0; m_ins = 0;
    n_handshakes = 0; n_pulses = 0;
    rst = 1'b1; i_req = 1'b0; i_wack = 1'b0;
    i_rd = '0; i_rd_wen = 1'b0; i_rd_wdata = '0; i_pc = '0; i_inst = '0;
    i_nocmt = 1'b0; i_skipcmt = 1'b0; i_intrNo = '0;
    @(posedge clk); #1;

    // Reset state, including ack ignored while empty.
    step(1, 1, mk(5'd3, 1, 64'hdead, 0), 1);
    step(1, 0, z, 0);
    step(0, 0, z, 1);

    // Single entry with commit ack held high.
    p0 = n_pulses; h0 = n_handshakes;
    step(0, 1, mk(5'd5, 1, 64'h1234, 0), 1);
    step(0, 0, z, 1);
    step(0, 0, z, 1);
    chk("single_pulses", 64'(n_pulses - p0), 64'd1);
    chk("single_hs", 64'(n_handshakes - h0), 64'd1);

    // Stall: downstream withholds ack for 4 cycles.
    p0 = n_pulses; h0 = n_handshakes;
    step(0, 1, mk(5'd7, 1, 64'hCAFE_F00D, 0), 0);
    for (int i = 0; i < 4; i++) step(0, 1, mk(5'd9, 1, 64'h99, 0), 0);
    step(0, 0, z, 1);
    step(0, 0, z, 1);
    chk("stall_pulses", 64'(n_pulses - p0), 64'd1);
    chk("stall_hs", 64'(n_handshakes - h0), 64'd1);

    // Back-to-back: three entries with no bubble.
    h0 = n_handshakes; ins0 = m_ins;
    for (int i = 0; i < 3; i++) step(0, 1, mk(5'(10 + i), 1, 64'(100 + i), 0), 1);
    step(0, 0, z, 1);
    chk("b2b_hs", 64'(n_handshakes - h0), 64'd3);
    chk("b2b_instret_model", m_ins - ins0, 64'd3);

    // Write to x0: regfile pulse suppressed, commit wen preserved.
    step(0, 1, mk(5'd0, 1, 64'h55, 0), 1);
    step(0, 0, z, 1);

    // nocmt entry: still handshakes, does not retire.
    ins0 = m_ins; h0 = n_handshakes;
    step(0, 1, mk(5'd12, 1, 64'h77, 1), 1);
    step(0, 0, z, 1);
    step(0, 0, z, 1);
    chk("nocmt_hs", 64'(n_handshakes - h0), 64'd1);
    chk("nocmt_instret_model", m_ins - ins0, 64'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      e = rand_ent();
      step(0, 1'($urandom_range(0, 2) != 0), e, 1'($urandom_range(0, 2) != 0));
    end

    // Reset while holding an entry discards it.
    step(0, 1, mk(5'd20, 1, 64'hABCD, 0), 0);
    step(0, 0, z, 0);
    step(1, 0, z, 1);
    p0 = n_pulses;
    step(0, 0, z, 1);
    step(0, 0, z, 1);
    chk("post_rst_pulses", 64'(n_pulses - p0), 64'd0);
    chk("post_rst_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_210544_wb_stage.md
YSYX_210544_WB_STAGE -- requirements
Module: ysyx_210544_wb_stage

Interface
REQ-001 SHALL have no parameters; widths come from the shared defines (BUS_64 = 64 bits, BUS_32 = 32 bits).
REQ-002 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_wb_memoryed_req  input  1  upstream (mem stage) has a valid instruction.
REQ-005 SHALL have o_wb_memoryed_ack  output  1  this stage accepts the upstream instruction this cycle.
REQ-006 SHALL have i_wb_rd / i_wb_rd_wen / i_wb_rd_wdata  input  5/1/64  destination register, write enable, write data.
REQ-007 SHALL have i_wb_pc / i_wb_inst  input  64/32  instruction address and encoding.
REQ-008 SHALL have i_wb_nocmt / i_wb_skipcmt / i_wb_intrNo  input  1/1/32  commit-suppress flag, difftest-skip flag, interrupt number.
REQ-009 SHALL have o_wb_rd / o_wb_rd_wen / o_wb_rd_wdata  output  5/1/64  register-file write port.
REQ-010 SHALL have o_wb_writebacked_req  output  1  held entry offered to the commit stage.
REQ-011 SHALL have i_wb_writebacked_ack  input  1  commit stage accepts the entry.
REQ-012 SHALL have o_wb_cmt_{rd,rd_wen,rd_wdata,pc,inst,nocmt,skipcmt,intrNo}  output  5/1/64/64/32/1/1/32  held-entry fields toward the commit stage.
REQ-013 SHALL have o_wb_perf_instret / o_wb_perf_cycle  output  64/64  performance counters (see Configuration).

Function
REQ-014 SHALL hold one entry (valid bit plus all REQ-006..008 fields) in registers; FSM states: EMPTY (valid=0) and HOLD (valid=1).
REQ-015 SHALL drive o_wb_memoryed_ack combinationally: 1 in EMPTY; in HOLD, 1 only when o_wb_writebacked_req & i_wb_writebacked_ack.
REQ-016 SHALL capture on upstream handshake (i_wb_memoryed_req & o_wb_memoryed_ack); the entry becomes visible the next cycle (latency 1).
REQ-017 SHALL implement these transitions: EMPTY -> HOLD on capture; HOLD -> EMPTY on downstream handshake without capture; HOLD -> HOLD with new fields when drain and capture happen in the same cycle (full throughput, no bubble).
REQ-018 SHALL assert o_wb_writebacked_req exactly while in HOLD, and keep all o_wb_cmt_* fields stable until the downstream handshake.
REQ-019 SHALL pulse o_wb_rd_wen for exactly one cycle, the first cycle of each captured entry, and never again for that entry however long it is stalled.
REQ-020 SHALL force o_wb_rd_wen = 0 when the captured rd = 0, while o_wb_cmt_rd_wen still reflects the input unchanged.
REQ-021 SHALL pass nocmt/skipcmt/intrNo through unmodified; entries with nocmt = 1 still occupy the entry and still handshake downstream.
REQ-022 SHALL ignore i_wb_writebacked_ack while in EMPTY.
REQ-023 SHALL drive o_wb_rd/o_wb_rd_wdata with the held fields in all states; they are don't-care when o_wb_rd_wen = 0.

Reset
REQ-024 SHALL, while rst = 1, force state to EMPTY, all held fields and all outputs to 0, o_wb_rd_wen to 0, and both counters to 0.
REQ-025 SHALL discard any HOLD entry when rst is asserted mid-operation: no write pulse and no commit request for it after reset.
REQ-026 SHALL drive o_wb_memoryed_ack = 0 while rst = 1.

Configuration
REQ-027 SHALL, with YSYX_210544_WB_PERF_EN defined: increment o_wb_perf_cycle every non-reset cycle (64-bit wrap), and increment o_wb_perf_instret on each downstream handshake whose nocmt = 0.
REQ-028 SHALL, without YSYX_210544_WB_PERF_EN, keep both perf ports present, tie them to 0, and compile in no counter registers.

Structure
REQ-029 SHALL take bus-width macros and FSM state encodings (EMPTY/HOLD) from the shared defines.v.
REQ-030 SHALL place the perf counters in the sub-module ysyx_210544_wb_perf; all other logic stays flat.

Verification
REQ-031 Single entry: rd = 5, wen = 1, wdata = 0x1234, commit ack held 1 -> one-cycle rd_wen pulse with rd = 5 and wdata = 0x1234 one cycle after capture; req high 1 cycle; stage returns to EMPTY.
REQ-032 Stall: commit ack = 0 for 4 cycles -> req and fields stable for 5 cycles; rd_wen pulses once; memoryed_ack = 0 during the stall.
REQ-033 Back-to-back: 3 entries with req and ack held 1 -> 3 consecutive commit handshakes with no bubble; instret increases by 3.
REQ-034 rd = 0 with wen = 1 -> o_wb_rd_wen stays 0; o_wb_cmt_rd_wen = 1.
REQ-035 nocmt = 1 entry -> handshakes downstream; instret unchanged; rd_wen follows the input.
REQ-036 rst asserted while in HOLD -> next cycle req = 0, all outputs 0, counters 0; without the PERF macro the perf outputs stay 0 throughout.
